// File: rtl/int_pkg.sv
// Shared types and defaults for the interrupt controller.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

  localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_0100;
  localparam int          DEF_VECTOR_STRIDE = 16;

  // Handler address for a source; the 32-bit result wraps naturally.
  function automatic logic [31:0] calc_vector_pc(input logic [31:0] base,
                                                 input logic [31:0] stride,
                                                 input logic [2:0]  id);
    calc_vector_pc = base + ({29'd0, id} * stride);
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: grants the lowest-index set request bit.
module int_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [2:0]         grant_o,
  output logic               valid_o
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    grant_o = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      grant_o = req_i[i] ? 3'(i) : grant_o;
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller, single level, no nesting.
// Define INT_CTRL_EDGE_EN for edge-triggered sources; level-sensitive otherwise.
module int_ctrl
  import int_pkg::*;
#(
  parameter int          NUM_SRC       = 8,
  parameter logic [31:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter int          VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               global_en,
  input  logic               if_interrupt,
  input  logic               reti,
  output logic               alert,
  output logic [31:0]        vector_pc,
  output logic [2:0]         int_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] mask
);

  int_state_t         state_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] eff_s;
  logic [2:0]         grant_s;
  logic               grant_vld_s;
  logic               alert_q;
  logic               in_service_q;
  logic [2:0]         int_id_q;
  logic [31:0]        vector_pc_q;

  assign eff_s = pending_q & mask_q;

  int_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req_i   (eff_s),
    .grant_o (grant_s),
    .valid_o (grant_vld_s)
  );

`ifdef INT_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] clr_s;

  // Acknowledge clears the served bit; a fresh rising edge in the same cycle wins.
  always_comb begin
    clr_s     = (state_q == REQ && if_interrupt) ? (NUM_SRC'(1) << int_id_q) : '0;
    pending_d = (pending_q & ~clr_s) | (irq & ~irq_q);
  end

  // Previous irq sample for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq;
    end
  end
`else
  // Level mode: pending simply tracks the registered line.
  always_comb begin
    pending_d = irq;
  end
`endif

  // Controller FSM with registered request/vector outputs and the mask register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      mask_q       <= '0;
      alert_q      <= 1'b0;
      in_service_q <= 1'b0;
      int_id_q     <= 3'd0;
      vector_pc_q  <= VECTOR_BASE;
    end else begin
      pending_q <= pending_d;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end else begin
        mask_q <= mask_q;
      end
      case (state_q)
        IDLE: begin
          if (global_en && grant_vld_s) begin
            state_q     <= REQ;
            alert_q     <= 1'b1;
            int_id_q    <= grant_s;
            vector_pc_q <= calc_vector_pc(VECTOR_BASE, 32'(VECTOR_STRIDE), grant_s);
          end else begin
            state_q <= IDLE;
          end
        end
        // Once issued, the request is only withdrawn by an acknowledge.
        REQ: begin
          if (if_interrupt) begin
            state_q      <= SERVICE;
            alert_q      <= 1'b0;
            in_service_q <= 1'b1;
          end else begin
            state_q <= REQ;
          end
        end
        SERVICE: begin
          if (reti) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end else begin
            state_q <= SERVICE;
          end
        end
        default: begin
          state_q      <= IDLE;
          alert_q      <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign alert      = alert_q;
  assign vector_pc  = vector_pc_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;
  assign mask       = mask_q;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8: number of interrupt sources, 2..8.
REQ-002 Parameter VECTOR_BASE, default 32'h0000_0100: PC of handler for source 0.
REQ-003 Parameter VECTOR_STRIDE, default 16: byte spacing between handler vectors; power of two.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 irq  input  NUM_SRC  raw interrupt source lines; bit 0 has highest priority.
REQ-007 mask_we  input  1  write strobe for enable mask.
REQ-008 mask_wdata  input  NUM_SRC  new enable mask; 1 = source enabled.
REQ-009 global_en  input  1  global interrupt enable from the control register.
REQ-010 if_interrupt  input  1  fetch stage took the interrupt redirect this cycle (acknowledge).
REQ-011 reti  input  1  return-from-interrupt retired this cycle.
REQ-012 alert  output  1  interrupt request to fetch stage.
REQ-013 vector_pc  output  32  handler PC; valid while alert=1.
REQ-014 int_id  output  3  ID of the requested or in-service source.
REQ-015 in_service  output  1  handler currently executing.
REQ-016 mask  output  NUM_SRC  current enable mask.

Function
REQ-017 State machine states: IDLE, REQ, SERVICE; state is registered.
REQ-018 pending[i] is a register per source; effective request eff = pending & mask.
REQ-019 IDLE -> REQ at the edge where global_en=1 and eff!=0; the lowest-index set bit of eff is latched into int_id at that edge.
REQ-020 alert SHALL be 1 exactly while state==REQ; the first alert cycle is the cycle after the qualifying eff condition.
REQ-021 int_id and vector_pc SHALL stay constant throughout REQ, even if a higher-priority source arrives.
REQ-022 vector_pc = VECTOR_BASE + int_id*VECTOR_STRIDE, computed in 32 bits with wrap-around modulo 2^32.
REQ-023 REQ -> SERVICE on if_interrupt=1; alert drops the next cycle; in_service=1 while in SERVICE.
REQ-024 In REQ, alert holds indefinitely until if_interrupt; global_en or mask deassertion SHALL NOT withdraw an issued alert.
REQ-025 SERVICE -> IDLE on reti=1; a new request may re-enter REQ no earlier than the cycle after IDLE is entered (no nesting).
REQ-026 reti in IDLE or REQ and if_interrupt outside REQ SHALL be ignored.
REQ-027 mask_we=1 updates mask at that edge in any state; the new mask affects eff from the next cycle.
REQ-028 pending bits SHALL continue to accumulate in REQ and SERVICE.

Reset
REQ-029 On rst_n=0 at a clock edge: state=IDLE, pending=0, mask=0, int_id=0, alert=0, in_service=0, vector_pc=VECTOR_BASE.
REQ-030 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the transaction with no acknowledge pending; the first post-reset cycle behaves as IDLE.

Configuration
REQ-031 Macro INT_CTRL_EDGE_EN defined: pending[i] is set on a 0->1 transition of irq[i] (one-cycle-delayed sample) and cleared on the if_interrupt edge for i==int_id; a set and a clear in the same cycle SHALL leave the bit set.
REQ-032 INT_CTRL_EDGE_EN undefined: level mode, pending[i] = irq[i] registered each cycle; no clear on acknowledge; the source must drop its line before reti.

Structure
REQ-033 Package int_pkg holds the state enum type (IDLE/REQ/SERVICE) and the default VECTOR_BASE/VECTOR_STRIDE constants.
REQ-034 Sub-module int_prio_enc (NUM_SRC-bit priority encoder: lowest-index grant plus valid) is natural and SHALL be used.

Verification
REQ-035 Reset, mask_we with mask_wdata=8'hFF, irq=8'h04, global_en=1 -> alert=1 two cycles later, int_id=2, vector_pc=32'h120.
REQ-036 irq=8'h0C simultaneously -> int_id=2; irq[0] raised during REQ -> int_id stays 2; after reti, alert again with int_id=0, vector_pc=32'h100.
REQ-037 Alert held 5 cycles without if_interrupt, global_en dropped meanwhile -> alert remains 1, vector_pc unchanged; if_interrupt -> alert=0 next cycle, in_service=1.
REQ-038 mask=8'h00, irq=8'h01 -> no alert; mask_we with mask_wdata=8'h01 -> alert asserted; reti in IDLE -> no effect.
REQ-039 Edge mode: if_interrupt coincident with a new rising edge on the same source -> pending stays 1, re-alert after reti; level mode: pending follows irq.
REQ-040 rst_n=0 during SERVICE -> next cycle all outputs at reset values, mask=0.
